// File: rtl/bus_fifo_pkg.sv
// Shared constants and types for the bus FIFO endpoint: pointer/count sizing
// helpers and the sticky overflow/underflow flag pair.
package bus_fifo_pkg;

    localparam int default_depth = 16;

    function automatic int ptr_bits(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int cnt_bits(input int d);
        return $clog2(d + 1);
    endfunction

    localparam int ptr_w = ptr_bits(default_depth);
    localparam int cnt_w = cnt_bits(default_depth);

    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_err_t;

endpackage

// File: rtl/fifo_core.sv
// First-word-fall-through circular FIFO with a separate occupancy count and
// sticky overflow/underflow flags. Used for both directions of the endpoint.
module fifo_core
    import bus_fifo_pkg::*;
#(
    parameter int width = 16,
    parameter int depth = 16,
    localparam int aw = ptr_bits(depth),
    localparam int cw = cnt_bits(depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [width-1:0] wr_data,
    input  logic             rd,
    output logic [width-1:0] rd_data,
    input  logic             err_clr,
    output logic [cw-1:0]    count,
    output logic             not_empty,
    output logic             full,
    output fifo_err_t        err
);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wptr;
    logic [aw-1:0]    rptr;
    logic             wr_ok;
    logic             rd_ok;
    fifo_err_t        err_ev;

    assign not_empty = (count != '0);
    assign full      = (count == cw'(depth));

    // A read frees a slot in the same edge, so a full FIFO still takes a
    // simultaneous write; an empty FIFO never reads the word being written.
    assign rd_ok = rd && not_empty;
    assign wr_ok = wr && (!full || rd_ok);

    assign err_ev.ovf = wr && !wr_ok;
    assign err_ev.udf = rd && !not_empty;

    assign rd_data = not_empty ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            err   <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + aw'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + aw'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
            // A new error in the clearing cycle wins over the clear.
            err.ovf <= (err.ovf && !err_clr) || err_ev.ovf;
            err.udf <= (err.udf && !err_clr) || err_ev.udf;
        end
    end

endmodule

// File: rtl/bus_fifo_endpoint.sv
// Per-port bus endpoint: a TX FIFO drained by the bus pop handshake and an
// RX FIFO filled by the bus push handshake, both facing a local device.
module bus_fifo_endpoint
    import bus_fifo_pkg::fifo_err_t;
#(
    parameter int pckg_sz = 16,
    parameter int depth   = 16,
    parameter int cnt_w   = $clog2(depth + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pop,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               dev_wr,
    input  logic [pckg_sz-1:0] dev_wr_data,
    output logic               tx_full,
    input  logic               dev_rd,
    output logic [pckg_sz-1:0] dev_rd_data,
    output logic               rx_valid,
    output logic               rx_full,
    output logic [cnt_w-1:0]   tx_count,
    output logic [cnt_w-1:0]   rx_count,
    input  logic               err_clr,
    output logic               tx_ovf,
    output logic               tx_udf,
    output logic               rx_ovf,
    output logic               rx_udf
);

    localparam int core_cw = $clog2(depth + 1);

    logic [core_cw-1:0] tx_cnt;
    logic [core_cw-1:0] rx_cnt;
    fifo_err_t          tx_err;
    fifo_err_t          rx_err;

    fifo_core #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk       (clk),
        .rst_n     (reset),
        .wr        (dev_wr),
        .wr_data   (dev_wr_data),
        .rd        (pop),
        .rd_data   (D_pop),
        .err_clr   (err_clr),
        .count     (tx_cnt),
        .not_empty (pndng),
        .full      (tx_full),
        .err       (tx_err)
    );

    fifo_core #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk       (clk),
        .rst_n     (reset),
        .wr        (push),
        .wr_data   (D_push),
        .rd        (dev_rd),
        .rd_data   (dev_rd_data),
        .err_clr   (err_clr),
        .count     (rx_cnt),
        .not_empty (rx_valid),
        .full      (rx_full),
        .err       (rx_err)
    );

    assign tx_count = cnt_w'(tx_cnt);
    assign rx_count = cnt_w'(rx_cnt);
    assign tx_ovf   = tx_err.ovf;
    assign tx_udf   = tx_err.udf;
    assign rx_ovf   = rx_err.ovf;
    assign rx_udf   = rx_err.udf;

endmodule

// File: tb/tb_bus_fifo_endpoint.sv
// Bench for bus_fifo_endpoint: fixed vector table, hand-written corner
// sequences, then random traffic checked against a queue-based model.
module tb_bus_fifo_endpoint;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          pop, push, dev_wr, dev_rd, err_clr;
  logic [W-1:0]  D_push, dev_wr_data;
  logic          pndng, tx_full, rx_valid, rx_full;
  logic [W-1:0]  D_pop, dev_rd_data;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf, tx_udf, rx_ovf, rx_udf;

  bus_fifo_endpoint #(.pckg_sz(W), .depth(D), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .pop(pop), .pndng(pndng), .D_pop(D_pop),
    .push(push), .D_push(D_push), .dev_wr(dev_wr), .dev_wr_data(dev_wr_data),
    .tx_full(tx_full), .dev_rd(dev_rd), .dev_rd_data(dev_rd_data),
    .rx_valid(rx_valid), .rx_full(rx_full), .tx_count(tx_count),
    .rx_count(rx_count), .err_clr(err_clr), .tx_ovf(tx_ovf), .tx_udf(tx_udf),
    .rx_ovf(rx_ovf), .rx_udf(rx_udf)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_tx_q[$];
  logic [W-1:0] exp_rx_q[$];
  logic m_tx_ovf, m_tx_udf, m_rx_ovf, m_rx_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_tx_q.delete();
    exp_rx_q.delete();
    m_tx_ovf = 1'b0; m_tx_udf = 1'b0; m_rx_ovf = 1'b0; m_rx_udf = 1'b0;
  endfunction

  // One clock edge of both FIFOs, stated as queue operations.
  function automatic void model_edge(input logic w, input logic [W-1:0] wd, input logic p,
                                     input logic ps, input logic [W-1:0] pd, input logic r,
                                     input logic c);
    bit tx_take, tx_put, rx_take, rx_put;
    tx_take = p && (exp_tx_q.size() > 0);
    tx_put  = w && ((exp_tx_q.size() < D) || tx_take);
    rx_take = r && (exp_rx_q.size() > 0);
    rx_put  = ps && ((exp_rx_q.size() < D) || rx_take);
    m_tx_ovf = (m_tx_ovf && !c) || (w && !tx_put);
    m_tx_udf = (m_tx_udf && !c) || (p && exp_tx_q.size() == 0);
    m_rx_ovf = (m_rx_ovf && !c) || (ps && !rx_put);
    m_rx_udf = (m_rx_udf && !c) || (r && exp_rx_q.size() == 0);
    if (tx_take) void'(exp_tx_q.pop_front());
    if (tx_put)  exp_tx_q.push_back(wd);
    if (rx_take) void'(exp_rx_q.pop_front());
    if (rx_put)  exp_rx_q.push_back(pd);
  endfunction

  task automatic check_model(input string tag);
    logic [W-1:0] tx_head, rx_head;
    tx_head = (exp_tx_q.size() > 0) ? exp_tx_q[0] : '0;
    rx_head = (exp_rx_q.size() > 0) ? exp_rx_q[0] : '0;
    chk({tag, ".pndng"},       32'(pndng),       32'(exp_tx_q.size() > 0));
    chk({tag, ".D_pop"},       32'(D_pop),       32'(tx_head));
    chk({tag, ".tx_count"},    32'(tx_count),    32'(exp_tx_q.size()));
    chk({tag, ".tx_full"},     32'(tx_full),     32'(exp_tx_q.size() == D));
    chk({tag, ".rx_valid"},    32'(rx_valid),    32'(exp_rx_q.size() > 0));
    chk({tag, ".dev_rd_data"}, 32'(dev_rd_data), 32'(rx_head));
    chk({tag, ".rx_count"},    32'(rx_count),    32'(exp_rx_q.size()));
    chk({tag, ".rx_full"},     32'(rx_full),     32'(exp_rx_q.size() == D));
    chk({tag, ".flags"}, 32'({tx_ovf, tx_udf, rx_ovf, rx_udf}),
        32'({m_tx_ovf, m_tx_udf, m_rx_ovf, m_rx_udf}));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1ns after a rising edge; outputs are sampled at that same point.
  task automatic step(input logic w, input logic [W-1:0] wd, input logic p,
                      input logic ps, input logic [W-1:0] pd, input logic r, input logic c);
    dev_wr = w; dev_wr_data = wd; pop = p; push = ps; D_push = pd; dev_rd = r; err_clr = c;
    model_edge(w, wd, p, ps, pd, r, c);
    @(posedge clk); #1;
    dev_wr = 1'b0; pop = 1'b0; push = 1'b0; dev_rd = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         wr;  logic [W-1:0] wd;  logic pop;
    logic         psh; logic [W-1:0] pd;  logic rd;  logic clr;
    logic         e_pndng; logic [W-1:0] e_dpop; int e_txc;
    logic         e_rxv;   logic [W-1:0] e_rdd;  int e_rxc;
    logic [3:0]   e_flags;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [W-1:0] wd, input logic p,
                              input logic ps, input logic [W-1:0] pd, input logic rd,
                              input logic clr, input logic ep, input logic [W-1:0] edp,
                              input int etc, input logic erv, input logic [W-1:0] erd,
                              input int erc, input logic [3:0] ef);
    vec_t v;
    v.wr = wr; v.wd = wd; v.pop = p; v.psh = ps; v.pd = pd; v.rd = rd; v.clr = clr;
    v.e_pndng = ep; v.e_dpop = edp; v.e_txc = etc;
    v.e_rxv = erv; v.e_rdd = erd; v.e_rxc = erc; v.e_flags = ef;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [W-1:0] v;
    reset = 1'b0; pop = 0; push = 0; dev_wr = 0; dev_rd = 0; err_clr = 0;
    D_push = '0; dev_wr_data = '0;
    model_reset();

    //          wr  wd       pop psh pd       rd clr | pndng D_pop  txc rxv rdd      rxc flags
    vecs.push_back(mk(1, 16'h0101, 0, 0, 16'h0000, 0, 0,   1, 16'h0101, 1, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(1, 16'h0202, 0, 0, 16'h0000, 0, 0,   1, 16'h0101, 2, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(1, 16'h0303, 0, 0, 16'h0000, 0, 0,   1, 16'h0101, 3, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0202, 2, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0303, 1, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0100));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0100));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0100));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h00AA, 1, 0,   0, 16'h0000, 0, 1, 16'h00AA, 1, 4'b0001));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 1, 0,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0001));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(1, 16'h1111, 0, 0, 16'h0000, 0, 0,   1, 16'h1111, 1, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(1, 16'h2222, 1, 0, 16'h0000, 0, 0,   1, 16'h2222, 1, 0, 16'h0000, 0, 4'b0000));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 0, 4'b0000));

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst.pndng", 32'(pndng), 0);
    chk("rst.D_pop", 32'(D_pop), 0);
    chk("rst.tx_count", 32'(tx_count), 0);
    chk("rst.rx_valid", 32'(rx_valid), 0);
    chk("rst.dev_rd_data", 32'(dev_rd_data), 0);
    chk("rst.rx_count", 32'(rx_count), 0);
    chk("rst.full", 32'({tx_full, rx_full}), 0);
    chk("rst.flags", 32'({tx_ovf, tx_udf, rx_ovf, rx_udf}), 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].pop, vecs[i].psh, vecs[i].pd, vecs[i].rd, vecs[i].clr);
      chk($sformatf("vec%0d.pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
      chk($sformatf("vec%0d.D_pop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
      chk($sformatf("vec%0d.tx_count", i), 32'(tx_count), 32'(vecs[i].e_txc));
      chk($sformatf("vec%0d.rx_valid", i), 32'(rx_valid), 32'(vecs[i].e_rxv));
      chk($sformatf("vec%0d.dev_rd_data", i), 32'(dev_rd_data), 32'(vecs[i].e_rdd));
      chk($sformatf("vec%0d.rx_count", i), 32'(rx_count), 32'(vecs[i].e_rxc));
      chk($sformatf("vec%0d.flags", i), 32'({tx_ovf, tx_udf, rx_ovf, rx_udf}), 32'(vecs[i].e_flags));
    end

    // TX fill to depth, then one write too many
    do_reset();
    for (int i = 0; i < D; i++) step(1, 16'h0A00 + 16'(i), 0, 0, '0, 0, 0);
    chk("fill.tx_full", 32'(tx_full), 1);
    chk("fill.tx_count", 32'(tx_count), 16);
    chk("fill.tx_ovf_before", 32'(tx_ovf), 0);
    step(1, 16'hDEAD, 0, 0, '0, 0, 0);
    chk("ovf.tx_ovf", 32'(tx_ovf), 1);
    chk("ovf.tx_count", 32'(tx_count), 16);
    for (int i = 0; i < D; i++) begin
      chk($sformatf("drain%0d.D_pop", i), 32'(D_pop), 32'(16'h0A00 + 16'(i)));
      step(0, '0, 1, 0, '0, 0, 0);
    end
    chk("drain.pndng", 32'(pndng), 0);
    chk("drain.D_pop", 32'(D_pop), 0);
    chk("drain.tx_ovf_sticky", 32'(tx_ovf), 1);

    // RX full with push and dev_rd together
    do_reset();
    for (int i = 0; i < D; i++) step(0, '0, 0, 1, 16'h1000 + 16'(i), 0, 0);
    chk("rxfull.rx_full", 32'(rx_full), 1);
    step(0, '0, 0, 1, 16'hBEEF, 1, 0);
    chk("rxboth.rx_count", 32'(rx_count), 16);
    chk("rxboth.rx_ovf", 32'(rx_ovf), 0);
    chk("rxboth.rx_full", 32'(rx_full), 1);
    chk("rxboth.head", 32'(dev_rd_data), 32'h1001);
    for (int i = 0; i < D - 1; i++) step(0, '0, 0, 0, '0, 1, 0);
    chk("rxboth.late_head", 32'(dev_rd_data), 32'hBEEF);
    chk("rxboth.late_count", 32'(rx_count), 1);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 16'h5000 + 16'(i), 0, (i < 2), 16'h6000 + 16'(i), 0, 0);
    chk("mid.tx_count", 32'(tx_count), 5);
    #2 reset = 1'b0;
    #1;
    chk("async.pndng", 32'(pndng), 0);
    chk("async.D_pop", 32'(D_pop), 0);
    chk("async.tx_count", 32'(tx_count), 0);
    chk("async.rx_count", 32'(rx_count), 0);
    chk("async.rx_valid", 32'(rx_valid), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    step(1, 16'h0A0A, 0, 0, '0, 0, 0);
    chk("resume.D_pop", 32'(D_pop), 32'h0A0A);
    check_model("resume");

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int wp, rp;
      wp = ((i / 75) % 2 == 0) ? 75 : 25;
      rp = 100 - wp;
      v = 16'($urandom_range(0, 16'hFFFF));
      step($urandom_range(0, 99) < wp, v, $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) < rp, 16'($urandom_range(0, 16'hFFFF)),
           $urandom_range(0, 99) < wp, $urandom_range(0, 19) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_fifo_endpoint.md
# bus_fifo_endpoint

Synthesizable per-device FIFO endpoint that sits on one port of the bus driver `bs_gnrtr_n_rbtr`. It answers the bus's pop/push handshake. A TX FIFO holds device packets, advertises them on `pndng`/`D_pop` and releases one per `pop`. An RX FIFO accepts packets the bus writes with `push`/`D_push` and presents them to the device. One instance is placed per driver port, so the bus can run against real storage instead of bench-modelled FIFOs.

## Interface
- `pckg_sz`, default 16: packet width in bits; opaque to this block.
- `depth`, default 16: entries per FIFO; power of two, ≥2.
- `cnt_w`, default `$clog2(depth+1)`: width of the occupancy counters.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low; flushes both FIFOs and clears all flags.
- `pop` input 1: bus consumes the TX head.
- `pndng` output 1: TX FIFO not empty.
- `D_pop` output pckg_sz: TX head packet; 0 when TX is empty.
- `push` input 1: bus writes `D_push` into RX.
- `D_push` input pckg_sz: packet from the bus.
- `dev_wr` input 1: device writes `dev_wr_data` into TX.
- `dev_wr_data` input pckg_sz: device packet.
- `tx_full` output 1: TX holds `depth` entries.
- `dev_rd` input 1: device consumes the RX head.
- `dev_rd_data` output pckg_sz: RX head packet; 0 when RX is empty.
- `rx_valid` output 1: RX not empty.
- `rx_full` output 1: RX holds `depth` entries.
- `tx_count`, `rx_count` output cnt_w: occupancy of each FIFO.
- `err_clr` input 1: synchronous clear of the sticky error flags.
- `tx_ovf`, `tx_udf`, `rx_ovf`, `rx_udf` output 1 each: sticky error flags.

## Operation
- Both FIFOs are first-word-fall-through circular buffers.
  - Read and write pointers are `$clog2(depth)` bits and wrap naturally.
  - The count is tracked separately (0..depth), so full and empty are never ambiguous.
- TX write: `dev_wr && !tx_full` stores the packet and increments `tx_count`. `dev_wr` while full drops the packet and sets `tx_ovf`.
- TX read: `pop && pndng` advances the read pointer and decrements the count. `pop` while empty is ignored and sets `tx_udf`.
- RX write (`push`) and RX read (`dev_rd`) mirror TX, setting `rx_ovf` and `rx_udf` respectively.
- Simultaneous write and read, same FIFO:
  - Non-empty and non-full: both are accepted; count unchanged.
  - Full: both are accepted; count stays `depth`; no overflow.
  - Empty: the write is accepted; the read is ignored and flags underflow. No bypass: data is never readable in the cycle it is written.
- Sticky flags:
  - They hold until `err_clr` or reset.
  - If `err_clr` and a new error occur in the same cycle, the flag ends set.
- `D_pop` and `dev_rd_data` are combinational from the storage array at the read pointer, gated to 0 when the FIFO is empty.
- `pndng`, `rx_valid`, `tx_full` and `rx_full` are decoded from registered counts.

## Timing
- Reset values: all pointers and counts 0; `pndng`, `rx_valid`, `tx_full`, `rx_full` 0; `D_pop`, `dev_rd_data` 0; all error flags 0. Storage contents are not reset.
- Reset asserted mid-operation: both FIFOs empty immediately (asynchronously); in-flight packets are lost.
- Write latency: a write at edge N is visible on `pndng`/`D_pop` (or `rx_valid`/`dev_rd_data`) after edge N, i.e. in cycle N+1.
- Read: a `pop` sampled at edge N presents the next head (or `pndng`=0) after edge N.
- The bus may hold `pop` high on consecutive cycles; the FIFO drains one entry per cycle.
- Error flags rise the cycle after the offending edge.

## Structure
- Package `bus_fifo_pkg`: `depth`-derived constants `ptr_w`, `cnt_w`, and the flag struct `fifo_err_t {ovf, udf}`.
- Sub-module `fifo_core` (params `width`, `depth`): storage, pointers, count, full/empty and the two sticky flags.
  - Instantiated twice: TX (writer = device, reader = bus) and RX (writer = bus, reader = device).
- Top level: port renaming and `err_clr` fan-out only.

## Test plan
- Reset release, then 3 `dev_wr` of 0x0101, 0x0202, 0x0303 → `pndng`=1 after the first write, `tx_count`=3, `D_pop`=0x0101; three `pop`s yield 0x0202, 0x0303, then `pndng`=0 with `D_pop`=0.
- Fill TX with 16 writes, then write 0xDEAD → `tx_full`=1, `tx_count`=16, `tx_ovf`=1, and 0xDEAD is never popped.
- `pop` on empty TX → `tx_udf`=1 and the count stays 0; `err_clr` → `tx_udf`=0 next cycle.
- RX full (16 entries) with `push` and `dev_rd` in the same cycle → count stays 16, `rx_ovf`=0, and the new packet appears 16 reads later.
- Empty RX with simultaneous `push` 0x00AA and `dev_rd` → `rx_udf`=1, `rx_count`=1, `dev_rd_data`=0x00AA next cycle.
- Assert `reset` low mid-stream with `tx_count`=5 → `pndng`=0, `D_pop`=0 and all counts 0 without a clock edge; traffic resumes normally after release.
